// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM encoding and the
// default ID/timestamp words expected from the sysid slave.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WAIT_ID = 3'd2,
    RD_TS   = 3'd3,
    WAIT_TS = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [31:0] DEFAULT_ID = 32'd1270204753;
  localparam logic [31:0] DEFAULT_TS = 32'd1308836030;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the sysid slave.
interface sysid_checker_if;

  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdata,
    output readdatavalid
  );

endinterface

// File: rtl/sysid_checker.sv
// Reads the sysid slave's ID (word 0) and timestamp (word 1), compares them
// with the expected values and reports status; each phase is time-limited.
//
//   state   | meaning
//   IDLE    | waiting for start, outputs held from last check
//   RD_ID   | read of word 0 requested, waiting for acceptance
//   WAIT_ID | word 0 accepted, waiting for readdatavalid
//   RD_TS   | read of word 1 requested, waiting for acceptance
//   WAIT_TS | word 1 accepted, waiting for readdatavalid
//   DONE    | check finished (done=1), results held until next start
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_TS,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] phase_cnt;
  logic        accepted;
  logic        phase_end;
  logic        exit_cond;
  logic        timeout_hit;
  logic        start_acc;

  assign accepted  = avm_read && !avm_waitrequest;
  assign phase_end = (phase_cnt == LAST_CNT);
  assign start_acc = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // The exit condition always beats the timeout in the same cycle.
  always_comb begin
    state_nxt   = state;
    exit_cond   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_nxt = RD_ID;
      RD_ID: begin
        exit_cond = accepted;
        if (accepted)       state_nxt = WAIT_ID;
        else if (phase_end) state_nxt = DONE;
      end
      WAIT_ID: begin
        exit_cond = avm_readdatavalid;
        if (avm_readdatavalid) state_nxt = RD_TS;
        else if (phase_end)    state_nxt = DONE;
      end
      RD_TS: begin
        exit_cond = accepted;
        if (accepted)       state_nxt = WAIT_TS;
        else if (phase_end) state_nxt = DONE;
      end
      WAIT_TS: begin
        exit_cond = avm_readdatavalid;
        if (avm_readdatavalid || phase_end) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (busy && phase_end && !exit_cond) timeout_hit = 1'b1;
  end

  always_comb begin
    avm_read    = 1'b0;
    avm_address = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      RD_ID:   begin avm_read = 1'b1; busy = 1'b1; end
      WAIT_ID: busy = 1'b1;
      RD_TS:   begin avm_read = 1'b1; avm_address = 1'b1; busy = 1'b1; end
      WAIT_TS: busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               phase_cnt <= 16'd0;
    else if (state_nxt != state) phase_cnt <= 16'd0;
    else if (busy)              phase_cnt <= phase_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else if (start_acc) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else begin
      if (state == WAIT_ID && avm_readdatavalid) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (state == WAIT_TS && avm_readdatavalid) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TS);
      end
      if (timeout_hit) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: a reactive Avalon slave model plus a
// scoreboard of expected check results popped when done rises.
module tb_sysid_checker;
  import sysid_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  sysid_checker_if bus ();

  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  sysid_checker #(
    .EXPECTED_ID   (DEFAULT_ID),
    .EXPECTED_TS   (DEFAULT_TS),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .avm_address      (bus.address),
    .avm_read         (bus.read),
    .avm_waitrequest  (bus.waitrequest),
    .avm_readdata     (bus.readdata),
    .avm_readdatavalid(bus.readdatavalid),
    .busy             (busy),
    .done             (done),
    .id_ok            (id_ok),
    .ts_ok            (ts_ok),
    .timeout          (timeout),
    .id_value         (id_value),
    .ts_value         (ts_value)
  );

  // Slave model: stalls 'stall' cycles per read, answers one cycle after acceptance.
  int          stall = 0;
  int          wait_cnt = 0;
  int          accepts = 0;
  logic [1:0]  rdv_en = 2'b11;
  logic [31:0] word0 = DEFAULT_ID;
  logic [31:0] word1 = DEFAULT_TS;
  logic        rdv_q = 1'b0;
  logic [31:0] rdata_q = 32'd0;
  logic        stray = 1'b0;

  assign bus.waitrequest   = bus.read && (wait_cnt < stall);
  assign bus.readdatavalid = rdv_q | stray;
  assign bus.readdata      = stray ? 32'hDEADBEEF : rdata_q;

  always @(posedge clk) begin
    rdv_q <= 1'b0;
    if (bus.read) begin
      if (wait_cnt < stall) wait_cnt <= wait_cnt + 1;
      else begin
        wait_cnt <= 0;
        accepts  <= accepts + 1;
        rdv_q    <= rdv_en[bus.address];
        rdata_q  <= bus.address ? word1 : word0;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // Request must stay unchanged in the cycle after any stalled cycle.
  logic prev_stall = 1'b0;
  logic prev_addr = 1'b0;
  int   unstable = 0;
  always @(negedge clk) begin
    if (prev_stall && !(bus.read && bus.address == prev_addr)) unstable <= unstable + 1;
    prev_stall <= bus.read && bus.waitrequest;
    prev_addr  <= bus.address;
  end

  typedef struct {
    logic [31:0] idv;
    logic [31:0] tsv;
    logic        iok;
    logic        tok;
    logic        tmo;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] idv, input logic [31:0] tsv,
                     input logic iok, input logic tok, input logic tmo, input int lat,
                     input bit repulse);
    exp_t e;
    exp_t g;
    int   n;
    e.idv = idv; e.tsv = tsv; e.iok = iok; e.tok = tok; e.tmo = tmo; e.lat = lat;
    sb.push_back(e);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      start = (repulse && n == 3);
    end
    start = 1'b0;
    chk({tag, " done"}, 32'(done), 32'd1);
    g = sb.pop_front();
    chk({tag, " latency"}, 32'(n), 32'(g.lat));
    chk({tag, " id_value"}, id_value, g.idv);
    chk({tag, " ts_value"}, ts_value, g.tsv);
    chk({tag, " id_ok"}, 32'(id_ok), 32'(g.iok));
    chk({tag, " ts_ok"}, 32'(ts_ok), 32'(g.tok));
    chk({tag, " timeout"}, 32'(timeout), 32'(g.tmo));
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " id_ok"}, 32'(id_ok), 32'd0);
    chk({tag, " ts_ok"}, 32'(ts_ok), 32'd0);
    chk({tag, " timeout"}, 32'(timeout), 32'd0);
    chk({tag, " id_value"}, id_value, 32'd0);
    chk({tag, " ts_value"}, ts_value, 32'd0);
    chk({tag, " avm_read"}, 32'(bus.read), 32'd0);
    chk({tag, " avm_address"}, 32'(bus.address), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int acc0;
    int n;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    acc0 = accepts;
    run("nominal", DEFAULT_ID, DEFAULT_TS, 1'b1, 1'b1, 1'b0, 5, 1'b0);
    chk("nominal reads", 32'(accepts - acc0), 32'd2);
    repeat (3) @(negedge clk);
    chk("hold done", 32'(done), 32'd1);
    chk("hold id_value", id_value, DEFAULT_ID);

    word0 = 32'h12345678;
    run("bad_id", 32'h12345678, DEFAULT_TS, 1'b0, 1'b1, 1'b0, 5, 1'b0);
    word0 = DEFAULT_ID;

    stall = 7;
    acc0 = accepts;
    run("stall7", DEFAULT_ID, DEFAULT_TS, 1'b1, 1'b1, 1'b0, 19, 1'b0);
    chk("stall7 reads", 32'(accepts - acc0), 32'd2);
    chk("stall7 addr stable", 32'(unstable), 32'd0);
    stall = 0;

    rdv_en = 2'b10;
    acc0 = accepts;
    run("to_wait_id", 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 10, 1'b0);
    chk("to_wait_id reads", 32'(accepts - acc0), 32'd1);
    rdv_en = 2'b11;

    stall = 8;
    acc0 = accepts;
    run("to_rd_id", 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 9, 1'b0);
    chk("to_rd_id read dropped", 32'(bus.read), 32'd0);
    chk("to_rd_id reads", 32'(accepts - acc0), 32'd0);
    stall = 0;

    acc0 = accepts;
    run("restart_busy", DEFAULT_ID, DEFAULT_TS, 1'b1, 1'b1, 1'b0, 5, 1'b1);
    chk("restart_busy reads", 32'(accepts - acc0), 32'd2);

    // Abort in WAIT_TS: the timestamp read is never answered before reset.
    rdv_en = 2'b01;
    acc0 = accepts;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    while ((accepts - acc0) < 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("abort reached WAIT_TS", 32'(busy && !bus.read && (accepts - acc0) == 2), 32'd1);
    chk("abort id captured", id_value, DEFAULT_ID);
    reset_n = 1'b0;
    #1;
    chk_all_zero("abort");
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    @(negedge clk);
    chk("stray busy", 32'(busy), 32'd0);
    chk("stray done", 32'(done), 32'd0);
    chk("stray id_value", id_value, 32'd0);
    chk("stray ts_value", ts_value, 32'd0);
    rdv_en = 2'b11;
    run("after_abort", DEFAULT_ID, DEFAULT_TS, 1'b1, 1'b1, 1'b0, 5, 1'b0);

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 1270204753, the 32-bit system ID value required at slave word 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 1308836030, the 32-bit timestamp value required at slave word 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the per-phase cycle limit (range 2..65535).
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL provide port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL provide port start, input, 1 bit: one-cycle request to begin a check.
REQ-007 SHALL provide port avm_address, output, 1 bit: word select (0 = ID, 1 = timestamp).
REQ-008 SHALL provide port avm_read, output, 1 bit: Avalon-MM read request.
REQ-009 SHALL provide port avm_waitrequest, input, 1 bit: slave stall; the request is accepted in a cycle with avm_read=1 and avm_waitrequest=0.
REQ-010 SHALL provide port avm_readdata, input, 32 bits: read data.
REQ-011 SHALL provide port avm_readdatavalid, input, 1 bit: avm_readdata qualifier.
REQ-012 SHALL provide ports busy, done, id_ok, ts_ok and timeout, outputs, 1 bit each: status.
REQ-013 SHALL provide ports id_value and ts_value, outputs, 32 bits each: captured words.

Function
REQ-014 SHALL implement states IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS and DONE.
REQ-015 SHALL move IDLE or DONE to RD_ID on start=1, clearing done, id_ok, ts_ok, timeout, id_value and ts_value in that same edge.
REQ-016 SHALL ignore start in every other state.
REQ-017 SHALL drive avm_read=1 only in RD_ID (avm_address=0) and RD_TS (avm_address=1), holding address stable until acceptance; otherwise avm_read=0 and avm_address=0.
REQ-018 SHALL move RD_ID to WAIT_ID and RD_TS to WAIT_TS on acceptance.
REQ-019 SHALL, on avm_readdatavalid=1 in WAIT_ID, capture avm_readdata into id_value, set id_ok=(avm_readdata==EXPECTED_ID) and go to RD_TS.
REQ-020 SHALL, on avm_readdatavalid=1 in WAIT_TS, capture avm_readdata into ts_value, set ts_ok=(avm_readdata==EXPECTED_TS) and go to DONE.
REQ-021 SHALL ignore avm_readdatavalid in IDLE, RD_ID, RD_TS and DONE.
REQ-022 SHALL keep a 16-bit phase counter, cleared on every state change and incrementing each cycle spent in RD_ID, WAIT_ID, RD_TS or WAIT_TS.
REQ-023 SHALL, when the phase counter equals TIMEOUT_CYCLES-1 and the phase's exit condition is false, set timeout=1 and go to DONE with avm_read=0 in the following cycle; the exit condition wins if both occur in the same cycle.
REQ-024 SHALL drive busy=1 in states other than IDLE and DONE, and done=1 in DONE.
REQ-025 SHALL hold done, id_ok, ts_ok, timeout, id_value and ts_value until the next accepted start.
REQ-026 SHALL give a minimum check latency of 5 cycles from start to done, reached with no wait states and readdatavalid one cycle after acceptance.

Reset
REQ-027 SHALL, on reset_n=0, asynchronously enter IDLE and clear the phase counter.
REQ-028 SHALL, on reset_n=0, asynchronously drive every output to 0.
REQ-029 SHALL, on reset mid-transaction, drop avm_read immediately and ignore any later readdatavalid from the aborted read.

Structure
REQ-030 SHALL take the state encoding and the default ID and timestamp constants from the shared project package sysid_pkg.
REQ-031 SHALL be a single module with no sub-modules; the phase counter stays inline.

Verification
REQ-032 SHALL cover this scenario: zero-wait slave returning 1270204753 then 1308836030; start -> done after 5 cycles, with id_ok=1, ts_ok=1 and timeout=0.
REQ-033 SHALL cover this scenario: slave returning 0x12345678 at word 0 -> id_value=0x12345678, id_ok=0, ts_ok=1 and done=1.
REQ-034 SHALL cover this scenario: waitrequest held 7 cycles on each read -> avm_read and avm_address stable throughout, and done after 19 cycles.
REQ-035 SHALL cover this scenario: TIMEOUT_CYCLES=8 with readdatavalid never asserted -> in WAIT_ID, timeout=1 and done=1 with id_ok=0 after 8 cycles.
REQ-036 SHALL cover this scenario: start pulsed again while busy -> ignored, with exactly two accepted reads in the sequence.
REQ-037 SHALL cover this scenario: reset_n low during WAIT_TS -> all outputs 0 at once; a stray readdatavalid afterwards changes nothing; a new start completes normally.
